// File: rtl/game_controller.sv
// Minesweeper play-state controller: map request handshake, cursor, reveal/flag masks,
// flood-fill of zero cells and win/loss detection for a fixed 8x8 board.
module game_controller (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] map_flat,
    input  logic         map_ready,
    output logic         map_rst,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_sel,
    input  logic         btn_flag,
    output logic [2:0]   cursor_row,
    output logic [2:0]   cursor_col,
    output logic [63:0]  revealed_flat,
    output logic [63:0]  flagged_flat,
    output logic         busy,
    output logic         game_over,
    output logic         game_won
);

    localparam int unsigned N_CELLS  = 64;
    localparam int unsigned CELL_W   = 4;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned COORD_W  = 3;

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_GEN  = 3'd1,
        S_PLAY = 3'd2,
        S_FILL = 3'd3,
        S_LOST = 3'd4,
        S_WON  = 3'd5
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_scan;
    logic                 r_changed;

    logic [N_CELLS-1:0]   w_mine;
    logic [N_CELLS-1:0]   w_zero;
    logic [N_CELLS-1:0]   w_zero_rev;
    logic [IDX_W-1:0]     w_cur_idx;
    logic                 w_win;
    logic                 w_nb_zero;
    logic                 w_fill_hit;
    logic                 w_pass_changed;
    int                   w_nr;
    int                   w_nc;

    // Decode per-cell mine and zero-count masks from the packed map
    always_comb begin
        w_mine = '0;
        w_zero = '0;
        for (int i = 0; i < int'(N_CELLS); i++) begin
            w_mine[i] = (map_flat[CELL_W*i +: CELL_W] >= 4'd9);
            w_zero[i] = (map_flat[CELL_W*i +: CELL_W] == 4'd0);
        end
    end

    assign w_zero_rev = revealed_flat & w_zero;
    assign w_cur_idx  = {cursor_row, cursor_col};
    assign w_win      = &(revealed_flat | w_mine);

    // Does the scanned cell have an in-board revealed zero neighbour
    always_comb begin
        w_nb_zero = 1'b0;
        w_nr      = 0;
        w_nc      = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                w_nr = int'(r_scan[5:3]) + dr;
                w_nc = int'(r_scan[2:0]) + dc;
                if (!(dr == 0 && dc == 0) && w_nr >= 0 && w_nr <= 7 && w_nc >= 0 && w_nc <= 7) begin
                    if (w_zero_rev[IDX_W'(w_nr * 8 + w_nc)]) begin
                        w_nb_zero = 1'b1;
                    end
                end
            end
        end
    end

    assign w_fill_hit = !revealed_flat[r_scan] && !flagged_flat[r_scan] &&
                        !w_mine[r_scan] && w_nb_zero;
    assign w_pass_changed = r_changed | w_fill_hit;

    // Controller state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_REQ;
            r_scan        <= '0;
            r_changed     <= 1'b0;
            map_rst       <= 1'b1;
            busy          <= 1'b1;
            cursor_row    <= '0;
            cursor_col    <= '0;
            revealed_flat <= '0;
            flagged_flat  <= '0;
            game_over     <= 1'b0;
            game_won      <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    map_rst <= 1'b0;
                    busy    <= 1'b1;
                    r_state <= S_GEN;
                end
                S_GEN: begin
                    if (map_ready) begin
                        revealed_flat <= '0;
                        flagged_flat  <= '0;
                        cursor_row    <= '0;
                        cursor_col    <= '0;
                        busy          <= 1'b0;
                        r_state       <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (w_win) begin
                        game_won <= 1'b1;
                        r_state  <= S_WON;
                    end else if (btn_sel) begin
                        if (!revealed_flat[w_cur_idx] && !flagged_flat[w_cur_idx]) begin
                            if (w_mine[w_cur_idx]) begin
                                revealed_flat <= revealed_flat | w_mine;
                                game_over     <= 1'b1;
                                r_state       <= S_LOST;
                            end else begin
                                revealed_flat[w_cur_idx] <= 1'b1;
                                if (w_zero[w_cur_idx]) begin
                                    busy      <= 1'b1;
                                    r_scan    <= '0;
                                    r_changed <= 1'b0;
                                    r_state   <= S_FILL;
                                end
                            end
                        end
                    end else if (btn_flag) begin
                        if (!revealed_flat[w_cur_idx]) begin
                            flagged_flat[w_cur_idx] <= !flagged_flat[w_cur_idx];
                        end
                    end else if (btn_up) begin
                        if (cursor_row != 3'd0) cursor_row <= cursor_row - COORD_W'(1);
                    end else if (btn_down) begin
                        if (cursor_row != 3'd7) cursor_row <= cursor_row + COORD_W'(1);
                    end else if (btn_left) begin
                        if (cursor_col != 3'd0) cursor_col <= cursor_col - COORD_W'(1);
                    end else if (btn_right) begin
                        if (cursor_col != 3'd7) cursor_col <= cursor_col + COORD_W'(1);
                    end
                end
                S_FILL: begin
                    if (w_fill_hit) begin
                        revealed_flat[r_scan] <= 1'b1;
                    end
                    if (r_scan == IDX_W'(N_CELLS - 1)) begin
                        r_scan <= '0;
                        if (w_pass_changed) begin
                            r_changed <= 1'b0;
                        end else begin
                            busy <= 1'b0;
                            if (w_win) begin
                                game_won <= 1'b1;
                                r_state  <= S_WON;
                            end else begin
                                r_state  <= S_PLAY;
                            end
                        end
                    end else begin
                        r_scan    <= r_scan + IDX_W'(1);
                        r_changed <= w_pass_changed;
                    end
                end
                S_LOST, S_WON: begin
                    if (btn_sel) begin
                        game_over <= 1'b0;
                        game_won  <= 1'b0;
                        map_rst   <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                default: begin
                    map_rst <= 1'b1;
                    busy    <= 1'b1;
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: navigation, flagging, flood-fill win, loss and mid-fill reset.
module tb_game_controller;

    logic         clk;
    logic         rst;
    logic [255:0] map_flat;
    logic         map_ready;
    logic         map_rst;
    logic         btn_up, btn_down, btn_left, btn_right, btn_sel, btn_flag;
    logic [2:0]   cursor_row, cursor_col;
    logic [63:0]  revealed_flat, flagged_flat;
    logic         busy, game_over, game_won;

    int n_vec;
    int n_err;

    game_controller u_dut (
        .clk           (clk),
        .rst           (rst),
        .map_flat      (map_flat),
        .map_ready     (map_ready),
        .map_rst       (map_rst),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_sel       (btn_sel),
        .btn_flag      (btn_flag),
        .cursor_row    (cursor_row),
        .cursor_col    (cursor_col),
        .revealed_flat (revealed_flat),
        .flagged_flat  (flagged_flat),
        .busy          (busy),
        .game_over     (game_over),
        .game_won      (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Neighbour-count map for a given mine mask
    function automatic logic [255:0] build_map(input logic [63:0] mines);
        logic [255:0] m;
        int cnt;
        m = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (mines[r*8+c]) begin
                    m[4*(r*8+c) +: 4] = 4'd9;
                end else begin
                    cnt = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr <= 7 && c+dc >= 0 && c+dc <= 7)
                                if (mines[(r+dr)*8 + (c+dc)]) cnt++;
                    m[4*(r*8+c) +: 4] = 4'(cnt);
                end
            end
        end
        return m;
    endfunction

    // One-cycle button pulse; bits are {sel, flag, up, down, left, right}
    task automatic press(input logic [5:0] b);
        @(negedge clk);
        {btn_sel, btn_flag, btn_up, btn_down, btn_left, btn_right} = b;
        @(negedge clk);
        {btn_sel, btn_flag, btn_up, btn_down, btn_left, btn_right} = '0;
    endtask

    task automatic press_n(input logic [5:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        map_ready = 1'b1;
        @(negedge clk);
        map_ready = 1'b0;
    endtask

    task automatic check_cursor(input string tag, input logic [2:0] r, input logic [2:0] c);
        check_val(tag, 64'({cursor_row, cursor_col}), 64'({r, c}));
    endtask

    localparam logic [5:0] B_SEL   = 6'b100000;
    localparam logic [5:0] B_FLAG  = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    logic [63:0] mines;
    int          n_busy;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        map_ready = 1'b0;
        {btn_sel, btn_flag, btn_up, btn_down, btn_left, btn_right} = '0;
        mines = 64'h0000_0000_0000_03FF;
        map_flat = build_map(mines);

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_map_rst", 64'(map_rst), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd1);
        check_val("rst_revealed", revealed_flat, 64'd0);
        check_val("rst_flags", {62'd0, game_over, game_won}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("gen_map_rst", 64'(map_rst), 64'd0);
        check_val("gen_busy", 64'(busy), 64'd1);
        press(B_RIGHT);
        check_cursor("gen_btn_dropped", 3'd0, 3'd0);
        pulse_ready();
        check_val("play_busy", 64'(busy), 64'd0);
        check_cursor("play_cursor", 3'd0, 3'd0);
        check_val("play_flagged", flagged_flat, 64'd0);

        // Navigation with saturation and priority
        press_n(B_RIGHT, 9);
        press(B_DOWN);
        check_cursor("nav_1_7", 3'd1, 3'd7);
        press(B_UP | B_DOWN);
        check_cursor("up_beats_down", 3'd0, 3'd7);
        press(B_DOWN);
        press_n(B_LEFT, 7);
        check_cursor("nav_1_0", 3'd1, 3'd0);
        press(B_LEFT);
        check_cursor("left_sat", 3'd1, 3'd0);
        press_n(B_UP, 2);
        check_cursor("up_sat", 3'd0, 3'd0);

        // Flag toggling and select on a flagged cell
        press(B_FLAG);
        check_val("flag_set", flagged_flat, 64'd1);
        press(B_FLAG);
        check_val("flag_clear", flagged_flat, 64'd0);
        press(B_FLAG);
        press(B_SEL);
        check_val("sel_flagged_noreveal", revealed_flat, 64'd0);
        check_val("sel_flagged_no_loss", 64'(game_over), 64'd0);

        // Reveal a numbered cell (1,2), then flag on it does nothing
        press(B_DOWN);
        press_n(B_RIGHT, 2);
        press(B_SEL);
        check_val("sel_number", revealed_flat, 64'h0000_0000_0000_0400);
        check_val("sel_number_busy", 64'(busy), 64'd0);
        press(B_FLAG);
        check_val("flag_on_revealed", flagged_flat, 64'd1);

        // Flood fill from (7,7) wins the board
        press_n(B_DOWN, 6);
        press_n(B_RIGHT, 5);
        check_cursor("nav_7_7", 3'd7, 3'd7);
        press(B_SEL);
        n_busy = 0;
        while (busy && n_busy < 2000) begin
            @(negedge clk);
            n_busy++;
        end
        check_val("fill_len_mod64", 64'(n_busy % 64), 64'd0);
        check_val("fill_multi_pass", 64'(n_busy >= 128 && n_busy < 2000), 64'd1);
        check_val("fill_revealed", revealed_flat, ~mines);
        check_val("fill_won", 64'(game_won), 64'd1);
        check_val("fill_not_over", 64'(game_over), 64'd0);

        // New game from WON
        press(B_SEL);
        check_val("won_req_map_rst", 64'(map_rst), 64'd1);
        check_val("won_req_won_clr", 64'(game_won), 64'd0);
        check_val("won_req_hold_rev", revealed_flat, ~mines);
        @(negedge clk);
        check_val("won_gen_map_rst", 64'(map_rst), 64'd0);
        pulse_ready();
        check_val("new_revealed", revealed_flat, 64'd0);
        check_val("new_flagged", flagged_flat, 64'd0);
        check_cursor("new_cursor", 3'd0, 3'd0);

        // Lose on mine idx 3 with idx 0 flagged
        press(B_FLAG);
        press_n(B_RIGHT, 3);
        press(B_SEL);
        check_val("lost_over", 64'(game_over), 64'd1);
        check_val("lost_revealed", revealed_flat, 64'h0000_0000_0000_03FF);
        check_val("lost_flag_kept", flagged_flat, 64'd1);
        check_val("lost_busy", 64'(busy), 64'd0);
        press(B_UP);
        check_cursor("lost_ignore_move", 3'd0, 3'd3);
        press(B_SEL);
        check_val("lost_req_map_rst", 64'(map_rst), 64'd1);
        check_val("lost_req_over_clr", 64'(game_over), 64'd0);
        @(negedge clk);
        check_val("lost_gen_map_rst", 64'(map_rst), 64'd0);

        // Async reset in the middle of a flood fill
        pulse_ready();
        press_n(B_DOWN, 7);
        press_n(B_RIGHT, 7);
        press(B_SEL);
        repeat (40) @(negedge clk);
        check_val("midfill_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_val("midfill_rst_map_rst", 64'(map_rst), 64'd1);
        check_val("midfill_rst_revealed", revealed_flat, 64'd0);
        check_cursor("midfill_rst_cursor", 3'd0, 3'd0);
        check_val("midfill_rst_busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rerst_gen_map_rst", 64'(map_rst), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
